// File: rtl/snake_pacer.sv
// -----------------------------------------------------------------------------
// snake_pacer
//   Step-rate controller for the snake game. Counts fruit, derives a speed
//   level from it and emits evenly spaced single-cycle step pulses whose rate
//   rises with the level. Also owns the IDLE/RUN/PAUSE/OVER sequencing that
//   gates the snake engine.
//
// Ports
//   clk          in   system clock
//   resetn       in   asynchronous active-low reset
//   start        in   pulse: new game from IDLE or OVER
//   pause_toggle in   pulse: RUN <-> PAUSE
//   game_over    in   level: freezes the pacer while high
//   fruit_event  in   pulse: one fruit eaten
//   step         out  single-cycle movement pulse
//   level        out  current speed level
//   fruit_count  out  fruits eaten this game (saturating)
//   level_up     out  single-cycle pulse when level increments
//   running      out  high while in RUN
// -----------------------------------------------------------------------------
module snake_pacer #(
  parameter int unsigned CLK_FREQ         = 50_000_000,
  parameter int unsigned BASE_HZ          = 4,
  parameter int unsigned STEP_HZ          = 2,
  parameter int unsigned NUM_LEVELS       = 4,
  parameter int unsigned FRUITS_PER_LEVEL = 5,
  parameter int unsigned CNT_W            = 8,
  parameter int unsigned LVL_W            = (NUM_LEVELS > 1) ? $clog2(NUM_LEVELS) : 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic             pause_toggle,
  input  logic             game_over,
  input  logic             fruit_event,
  output logic             step,
  output logic [LVL_W-1:0] level,
  output logic [CNT_W-1:0] fruit_count,
  output logic             level_up,
  output logic             running
);

  // Level 0 has the longest period, so it sizes the period counter.
  localparam int unsigned P0        = CLK_FREQ / BASE_HZ;
  localparam int unsigned PER_W     = (P0 > 1) ? $clog2(P0) : 1;
  localparam int unsigned MOD_W     = (FRUITS_PER_LEVEL > 1) ? $clog2(FRUITS_PER_LEVEL) : 1;
  localparam int unsigned LVL_SLOTS = 1 << LVL_W;

  localparam logic [LVL_W-1:0] LVL_MAX = LVL_W'(NUM_LEVELS - 1);
  localparam logic [MOD_W-1:0] MOD_MAX = MOD_W'(FRUITS_PER_LEVEL - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_PAUSE = 2'd2,
    S_OVER  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic             new_game;
  logic             stay_run;
  logic             wrap;
  logic [PER_W-1:0] cnt_q;
  logic [MOD_W-1:0] mod_q;
  logic             fruit_ok;
  logic             bump;
  logic             mod_wrap;
  logic             lvl_inc;

  // ---------------------------------------------------------------------------
  // Per-level wrap limits (PERIOD[L]-1), fixed at elaboration. The table is
  // padded to a power of two with the last level so that any value of the
  // level register indexes a defined entry.
  // ---------------------------------------------------------------------------
  logic [PER_W-1:0] per_lim [LVL_SLOTS];

  for (genvar g = 0; g < LVL_SLOTS; g++) begin : g_per
    localparam int unsigned LV = (g < NUM_LEVELS) ? g : NUM_LEVELS - 1;
    localparam int unsigned PG = CLK_FREQ / (BASE_HZ + LV * STEP_HZ);
    assign per_lim[g] = PER_W'(PG - 1);
  end

  // ---------------------------------------------------------------------------
  // Game sequencing
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    new_game = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_RUN;
          new_game = 1'b1;
        end
      end
      S_RUN: begin
        if (game_over)         state_d = S_OVER;
        else if (pause_toggle) state_d = S_PAUSE;
      end
      S_PAUSE: begin
        if (game_over)         state_d = S_OVER;
        else if (pause_toggle) state_d = S_RUN;
      end
      S_OVER: begin
        // A new game cannot start while the engine still reports game over.
        if (start && !game_over) begin
          state_d  = S_RUN;
          new_game = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      running <= 1'b0;
    end else begin
      state_q <= state_d;
      running <= (state_d == S_RUN);
    end
  end

  // ---------------------------------------------------------------------------
  // Period counter and step pulse.
  // The counter only moves on edges that stay in RUN: the edge that leaves
  // RUN freezes it, so a pause resumes with the same phase and a wrap that
  // would coincide with leaving RUN is dropped. The >= compare catches a
  // level-up that lands after the counter already passed the shorter limit.
  // ---------------------------------------------------------------------------
  assign stay_run = (state_q == S_RUN) && (state_d == S_RUN);
  assign wrap     = (cnt_q >= per_lim[level]);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
      step  <= 1'b0;
    end else begin
      step <= stay_run && wrap;
      if (new_game)      cnt_q <= '0;
      else if (stay_run) cnt_q <= wrap ? '0 : cnt_q + 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Fruit accounting.
  // mod_q tracks fruit_count modulo FRUITS_PER_LEVEL so no runtime divider is
  // needed; it stops with the count once the count saturates, so a saturated
  // counter never produces further level increments.
  // ---------------------------------------------------------------------------
  assign fruit_ok = fruit_event && ((state_q == S_RUN) || (state_q == S_PAUSE));
  assign bump     = fruit_ok && !(&fruit_count);
  assign mod_wrap = (mod_q == MOD_MAX);
  assign lvl_inc  = bump && mod_wrap && (level != LVL_MAX);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fruit_count <= '0;
      mod_q       <= '0;
      level       <= '0;
      level_up    <= 1'b0;
    end else begin
      level_up <= lvl_inc;
      if (new_game) begin
        fruit_count <= '0;
        mod_q       <= '0;
        level       <= '0;
      end else if (bump) begin
        fruit_count <= fruit_count + 1'b1;
        mod_q       <= mod_wrap ? '0 : mod_q + 1'b1;
        if (lvl_inc) level <= level + 1'b1;
      end
    end
  end

endmodule

// File: doc/snake_pacer.md
# snake_pacer

Parametrised step-rate controller for the snake game. It replaces the fixed base-tick/pulse-burst speed logic in the game top level. It counts fruit events, derives a speed level, and emits evenly spaced single-cycle `step` pulses whose rate rises with the level. It also owns the run/pause/game-over sequencing that gates the snake engine. It sits between the input/scoring logic and `snake_engine.step`.

## Interface
Parameters:
- `CLK_FREQ`, 50_000_000, input clock frequency in Hz
- `BASE_HZ`, 4, step rate at level 0
- `STEP_HZ`, 2, rate added per level; level L runs at BASE_HZ + L*STEP_HZ
- `NUM_LEVELS`, 4, number of speed levels (≥1)
- `FRUITS_PER_LEVEL`, 5, fruits needed per level increment (≥1)
- `CNT_W`, 8, fruit counter width
- `LVL_W`, derived, $clog2(NUM_LEVELS), minimum 1

Ports:
- `clk`  in  1  system clock
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  single-cycle pulse; starts a new game from IDLE or OVER
- `pause_toggle`  in  1  single-cycle pulse; toggles RUN↔PAUSE
- `game_over`  in  1  level; freezes the pacer when high
- `fruit_event`  in  1  single-cycle pulse per fruit eaten
- `step`  out  1  single-cycle movement pulse
- `level`  out  LVL_W  current speed level
- `fruit_count`  out  CNT_W  fruits eaten this game, saturating
- `level_up`  out  1  single-cycle pulse when `level` increments
- `running`  out  1  high while in RUN

## Operation
- States: IDLE, RUN, PAUSE, OVER.
- IDLE: `start` → RUN.
- RUN: `game_over` → OVER (highest priority). Otherwise `pause_toggle` → PAUSE.
- PAUSE: `game_over` → OVER. Otherwise `pause_toggle` → RUN.
- OVER: `start` → RUN, but only when `game_over` is low; otherwise OVER holds.
- Entering RUN from IDLE or OVER clears `fruit_count`, `level` and the period counter to 0.
- Entering RUN from PAUSE keeps the period counter value, so phase is preserved.
- Per-level periods are elaboration-time constants: PERIOD[L] = CLK_FREQ / (BASE_HZ + L*STEP_HZ), integer floor. There is no runtime divider.
- Period counter: advances only in RUN. When it reaches ≥ PERIOD[level]-1, it wraps to 0 and `step` is asserted on the next cycle.
  - The ≥ comparison covers a level-up that lands while the counter is already past the new, shorter period.
- `fruit_event`:
  - Counted in RUN and PAUSE; ignored in IDLE and OVER.
  - `fruit_count` saturates at 2^CNT_W-1.
  - A fruit that makes `fruit_count` a multiple of FRUITS_PER_LEVEL increments `level` and pulses `level_up`, provided `level` < NUM_LEVELS-1.
  - `level` saturates at NUM_LEVELS-1; no `level_up` pulse is issued at saturation.
- Simultaneous events in one cycle:
  - `fruit_event` with `pause_toggle`: both take effect.
  - `fruit_event` with `game_over`: the fruit is counted, then the state goes to OVER.
  - `start` with `pause_toggle` in IDLE/OVER: `start` wins and `pause_toggle` is ignored.
- No `step` pulse is issued in IDLE, PAUSE or OVER. A wrap pending when the state leaves RUN is dropped.

## Timing
- Reset (asynchronous, any state, including mid-period): state IDLE.
  - `step` = 0, `level_up` = 0, `running` = 0, `level` = 0, `fruit_count` = 0, counter = 0.
- All outputs are registered.
- `running` is high in the cycle after the edge that enters RUN.
- First `step` is high exactly PERIOD[0] cycles after the `start` edge. Subsequent pulses follow every PERIOD[level] cycles.
- `fruit_count` and `level` update one cycle after the `fruit_event` edge. `level_up` is high in that same cycle.
- A new level's period applies from the counter cycle following the `level` update.

## Test plan
Bench parameters: CLK_FREQ=1000, BASE_HZ=100, STEP_HZ=25, NUM_LEVELS=4, FRUITS_PER_LEVEL=2, CNT_W=4. This gives periods 10/8/6/5.
- Reset, then pulse `start` → `running`=1 next cycle; `step` at cycles 10, 20, 30 after `start`; no step before cycle 10.
- In RUN, issue 2 `fruit_event` → `fruit_count`=2, `level`=1, one `level_up` pulse; step spacing becomes 8. Issue 6 more fruits → `level` stays 3 after the sixth; spacing 5; exactly 3 `level_up` pulses in total.
- Issue 20 fruits → `fruit_count` saturates at 15 and `level` at 3.
- `pause_toggle` at counter=4 for 30 cycles, then `pause_toggle` → no steps during PAUSE; next step 6 cycles after resume (level 0).
- Assert `game_over` in the same cycle as `fruit_event` → count increments, OVER entered, no further steps. `start` while `game_over`=1 → stays OVER. Release `game_over`, then `start` → counts cleared, first step 10 cycles later.
- Deassert `resetn` mid-period at level 2 → all outputs 0 immediately; state IDLE after release.
